// File: rtl/mm_pkg.sv
// Shared types and sizing for the matrix-multiply sequencer.
package mm_pkg;

    localparam int DIM_W   = 4;
    localparam int ADDR_W  = 8;
    localparam int MAC_LAT = 2;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MAC,
        DRAIN,
        ILLEGAL,
        DONE
    } state_t;

endpackage

// File: rtl/mm_idx_cnt.sv
// Nested i/j/k index counter (k innermost) with registered row-major operand addresses.
module mm_idx_cnt
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    input  logic [DIM_W-1:0]  dim_m,
    input  logic [DIM_W-1:0]  dim_n,
    input  logic [DIM_W-1:0]  dim_q,
    output logic              k_wrap,
    output logic              j_wrap,
    output logic              i_wrap,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr
);

    localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

    logic [DIM_W-1:0] i_q, j_q, k_q;
    logic [DIM_W-1:0] i_nxt, j_nxt, k_nxt;

    assign k_wrap = (k_q == dim_n - ONE);
    assign j_wrap = (j_q == dim_q - ONE);
    assign i_wrap = (i_q == dim_m - ONE);

    always_comb begin
        k_nxt = k_q + ONE;
        j_nxt = j_q;
        i_nxt = i_q;
        if (k_wrap) begin
            k_nxt = '0;
            j_nxt = j_q + ONE;
            if (j_wrap) begin
                j_nxt = '0;
                i_nxt = i_q + ONE;
            end
        end
    end

    // Addresses are computed from the next indices so they line up with the registered mac_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            a_addr <= '0;
            b_addr <= '0;
        end else if (clr) begin
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            a_addr <= '0;
            b_addr <= '0;
        end else if (adv) begin
            i_q    <= i_nxt;
            j_q    <= j_nxt;
            k_q    <= k_nxt;
            a_addr <= ADDR_W'(i_nxt) * ADDR_W'(dim_n) + ADDR_W'(k_nxt);
            b_addr <= ADDR_W'(k_nxt) * ADDR_W'(dim_q) + ADDR_W'(j_nxt);
        end
    end

endmodule

// File: rtl/mm_seq_ctrl.sv
// Matrix-multiply sequencer: shape check, MAC address/enable generation and result tagging.
module mm_seq_ctrl
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  dim_m,
    input  logic [DIM_W-1:0]  dim_n,
    input  logic [DIM_W-1:0]  dim_p,
    input  logic [DIM_W-1:0]  dim_q,
    output logic              busy,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              out_valid,
    output logic              change_row,
    output logic              is_legal,
    output logic              done
);

    state_t state_q, state_nxt;

    logic [DIM_W-1:0] m_q, n_q, p_q, q_q;
    logic shape_ok, last_mac, cnt_clr, cnt_adv;
    logic k_wrap, j_wrap, i_wrap;
    logic vld_p0, vld_p1, row_p0, row_p1;

    assign shape_ok = (n_q == p_q) && (m_q != '0) && (n_q != '0) && (q_q != '0);
    assign last_mac = k_wrap && j_wrap && i_wrap;

    // Shape is data: captured only on an accepted start, never reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            m_q <= dim_m;
            n_q <= dim_n;
            p_q <= dim_p;
            q_q <= dim_q;
        end
    end

    mm_idx_cnt u_idx_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .adv    (cnt_adv),
        .dim_m  (m_q),
        .dim_n  (n_q),
        .dim_q  (q_q),
        .k_wrap (k_wrap),
        .j_wrap (j_wrap),
        .i_wrap (i_wrap),
        .a_addr (a_addr),
        .b_addr (b_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        cnt_clr   = 1'b0;
        cnt_adv   = 1'b0;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        case (state_q)
            IDLE:    if (start) state_nxt = CHECK;
            CHECK: begin
                if (shape_ok) begin
                    state_nxt = MAC;
                    cnt_clr   = 1'b1;
                end else begin
                    state_nxt = ILLEGAL;
                end
            end
            MAC: begin
                if (last_mac) state_nxt = DRAIN;
                else          cnt_adv   = 1'b1;
            end
            // Leave once only the final tag stage is still occupied.
            DRAIN:   if (!vld_p0) state_nxt = DONE;
            ILLEGAL: state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: tag the k=n-1 MAC cycle; stage p1: result emerges from the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_en   <= 1'b0;
            mac_clr  <= 1'b0;
            is_legal <= 1'b0;
            vld_p0   <= 1'b0;
            row_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            row_p1   <= 1'b0;
        end else begin
            mac_en  <= (state_nxt == MAC);
            mac_clr <= (state_nxt == MAC) && (cnt_clr || k_wrap);
            if (state_q == CHECK) is_legal <= shape_ok;
            vld_p0  <= mac_en && k_wrap;
            row_p0  <= mac_en && k_wrap && j_wrap;
            vld_p1  <= vld_p0;
            row_p1  <= row_p0;
        end
    end

    assign out_valid  = vld_p1 || (state_q == ILLEGAL);
    assign change_row = row_p1;

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Directed bench for mm_seq_ctrl: shapes, boundaries, reset abort and start-while-busy.
module tb_mm_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dim_m, dim_n, dim_p, dim_q;
    logic       busy, mac_en, mac_clr, out_valid, change_row, is_legal, done;
    logic [7:0] a_addr, b_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mm_seq_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dim_m      (dim_m),
        .dim_n      (dim_n),
        .dim_p      (dim_p),
        .dim_q      (dim_q),
        .busy       (busy),
        .a_addr     (a_addr),
        .b_addr     (b_addr),
        .mac_en     (mac_en),
        .mac_clr    (mac_clr),
        .out_valid  (out_valid),
        .change_row (change_row),
        .is_legal   (is_legal),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one job from a negedge; cycle 1 is the cycle after the start-sampling edge.
    task automatic run_job(input int m, input int n, input int p, input int q,
                           input int inj_cyc, input int limit);
        int cyc, macs, clrs, ovs, done_cyc, first_mac, last_mac, total, e;
        int ei, ej, ek;
        bit legal;
        logic [7:0] last_a, last_b;
        legal     = (n == p) && (m != 0) && (n != 0) && (q != 0);
        total     = legal ? m * q * n : 0;
        macs      = 0;
        clrs      = 0;
        ovs       = 0;
        done_cyc  = 0;
        first_mac = 0;
        last_mac  = 0;
        last_a    = '0;
        last_b    = '0;
        start = 1'b1;
        dim_m = 4'(m); dim_n = 4'(n); dim_p = 4'(p); dim_q = 4'(q);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk("busy_rise", busy, 1);
        while (done_cyc == 0 && cyc < limit) begin
            if (mac_en) begin
                if (first_mac == 0) first_mac = cyc;
                ek = macs % n;
                ej = (macs / n) % q;
                ei = macs / (n * q);
                chk("a_addr", a_addr, ei * n + ek);
                chk("b_addr", b_addr, ek * q + ej);
                chk("mac_clr", mac_clr, (ek == 0));
                if (mac_clr) clrs++;
                last_a = a_addr;
                last_b = b_addr;
                macs++;
                last_mac = cyc;
            end
            if (out_valid) begin
                if (legal) begin
                    e = ovs;
                    chk("ov_cycle", cyc, 3 + (e + 1) * n);
                    chk("change_row", change_row, ((e % q) == q - 1));
                end else begin
                    chk("ill_cycle", cyc, 2);
                    chk("ill_is_legal", is_legal, 0);
                    chk("ill_change_row", change_row, 0);
                    chk("ill_mac_en", mac_en, 0);
                end
                ovs++;
            end
            if (done) done_cyc = cyc;
            if (cyc == inj_cyc) begin
                start = 1'b1;
                dim_m = 4'd3; dim_n = 4'd3; dim_p = 4'd3; dim_q = 4'd3;
            end else begin
                start = 1'b0;
            end
            if (done_cyc == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk("done_seen", (done_cyc != 0), 1);
        chk("mac_count", macs, total);
        chk("clr_count", clrs, legal ? m * q : 0);
        chk("ov_count", ovs, legal ? m * q : 1);
        chk("done_cycle", done_cyc, legal ? 4 + total : 3);
        chk("is_legal", is_legal, legal);
        if (legal) begin
            chk("first_mac", first_mac, 2);
            chk("mac_contig", last_mac - first_mac + 1, macs);
            chk("final_a", last_a, (m - 1) * n + (n - 1));
            chk("final_b", last_b, (n - 1) * q + (q - 1));
        end
        @(negedge clk);
        chk("busy_fall", busy, 0);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        int ov_seen, done_seen;
        rst   = 1'b1;
        start = 1'b0;
        dim_m = '0; dim_n = '0; dim_p = '0; dim_q = '0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {busy, mac_en, mac_clr, out_valid, change_row, done, is_legal}, 0);
        chk("rst_addr", {a_addr, b_addr}, 0);
        rst = 1'b0;

        run_job(2, 3, 3, 2, 0, 100);
        run_job(1, 1, 1, 1, 0, 100);
        run_job(2, 3, 2, 2, 0, 100);
        run_job(0, 3, 3, 2, 0, 100);
        run_job(15, 15, 15, 15, 0, 4000);
        run_job(2, 2, 2, 3, 5, 100);

        // Abort a 3x3 * 3x3 run in the middle of MAC.
        start = 1'b1;
        dim_m = 4'd3; dim_n = 4'd3; dim_p = 4'd3; dim_q = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_abort_mac", mac_en, 1);
        rst = 1'b1;
        #1;
        chk("abort_ctrl", {busy, mac_en, mac_clr, out_valid, change_row, done, is_legal}, 0);
        chk("abort_addr", {a_addr, b_addr}, 0);
        ov_seen   = 0;
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
            if (done) done_seen++;
        end
        chk("abort_no_ov", ov_seen, 0);
        chk("abort_no_done", done_seen, 0);
        rst = 1'b0;
        run_job(1, 1, 1, 1, 0, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
